tt_um_freq_counter: RTL and testbench
=====================================

// Module: tt_um_freq_counter
// PURPOSE
//  Gated frequency counter; the measuring end of a free-running counter link.
//  Counts rising edges of an external pin over a programmable gate window and latches the count.
//  The latched result is read back byte-wise on uo_out. TinyTapeout top; sits beside the 8-bit counter tile.
// PARAMETERS
//  CNT_W        16   width of edge counter and latched result
//  GATE_W        8   width of gate-length register G
//  UNIT         16   clk cycles per gate unit; window = G*UNIT cycles
//  SYNC_STAGES   2   flops in sig_in/start synchronizer (>=2)
// PORTS
//  clk      in   1  clock
//  rst_n    in   1  reset; synchronous, active-low, sampled on rising clk
//  ena      in   1  ignored
//  ui_in    in   8  [0] sig_in (async)  [1] start (async)  [2] cont mode
//                   [3] load_g  [5:4] rd_sel  [7:6] unused
//  uio_in   in   8  gate length G, captured when load_g=1
//  uo_out   out  8  rd_sel 00: result[7:0]; 01: result[15:8]
//                   10: {busy,done,ovf,5'b0}; 11: G
//  uio_out  out  8  constant 8'h00
//  uio_oe   out  8  constant 8'h00; all uio pins are inputs
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, count=0, result=0, G=0, done=0, ovf=0, timers=0.
//   Reset mid-window aborts the measurement, with no latch.
//   uo_out=8'h00 on the cycle after reset for rd_sel=00/01/10/11.
//  sig_in and start each pass through SYNC_STAGES flops, then a 1-flop rising-edge detect.
//   Pin edge -> edge pulse SYNC_STAGES+1 cycles later.
//  load_g: G<=uio_in when state=IDLE or DONE. It is ignored while busy.
//   load_g and a start pulse in the same cycle: load wins and start is dropped.
//  FSM states: IDLE, GATE, DONE.
//   IDLE -(start pulse, G!=0)-> GATE; count<=0 and timer<=G*UNIT-1.
//   IDLE -(start pulse, G==0)-> DONE; result<=0, ovf<=0, done<=1.
//   GATE: each cycle, timer decrements and each edge pulse increments count.
//    Count saturates at 2^CNT_W-1 and sets the sticky window ovf flag.
//   GATE, timer==0: result<=count + (edge pulse this cycle), with the same saturation.
//    Then ovf is latched, done<=1, and the next state is DONE (cont=0) or GATE (cont=1).
//    On a cont=1 restart, count restarts at 0 and timer reloads from G in the same cycle, with no dead cycle.
//   DONE -(start pulse)-> GATE with done<=0. G==0 is handled as in IDLE.
//   Start pulses while in GATE are ignored.
//  Window is exactly G*UNIT cycles. Edge pulses in those cycles are counted, and no other pulses are.
//  busy = (state==GATE). done is sticky until the next start or reset.
//  result holds its value between latches, so reads are stable at any time.
//  Timer width is GATE_W+clog2(UNIT). G*UNIT must not wrap.
//  uo_out is a registered mux of rd_sel: 1-cycle read latency.
// STRUCTURE
//  Header tt_freq_pkg.vh holds:
//   - state encodings ST_IDLE/ST_GATE/ST_DONE
//   - status bit indices STS_BUSY=7, STS_DONE=6, STS_OVF=5
//   - rd_sel codes
//  Sub-module freq_sync_edge #(SYNC_STAGES): synchronizer plus rising-edge pulse; instantiated twice (sig_in, start).
//  The top holds the FSM, timer, counter, result and readback mux.
// TESTING
//  1 Reset: hold rst_n=0 for 3 clk, then release.
//    -> uo_out=00 for rd_sel 0..3; status=8'h00.
//  2 Basic window, UNIT=16: G=4, start, sig_in rising every 8 clk.
//    -> done after 64-cycle window; result=16'd8; status=8'h40.
//  3 G=0 plus start -> DONE within 4 cycles of the start pin edge; result=0; busy never set.
//  4 Saturation, CNT_W=4 build: G=4, sig_in toggling every clk (edge every 2 clk, 32 edges).
//    -> result=16'h000F; ovf=1; status=8'h60.
//  5 Continuous mode: cont=1, G=2, edge every 4 clk.
//    -> result=8 after each window; windows back-to-back every 32 clk with no lost edge.
//    Deassert cont -> stops in DONE after the current window.
//  6 Abort and priority:
//    - rst_n=0 mid-GATE -> IDLE; result stays 0.
//    - load_g=1 with start in the same cycle -> G updated; state stays IDLE.
//    - load_g while busy -> G unchanged.

Source files
------------

// File: rtl/tt_freq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tt_freq_pkg
// Description : Shared state encodings, status bit positions and readback
//               select codes for the gated frequency counter.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_freq_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit positions inside the status byte
    localparam int STS_BUSY = 7;
    localparam int STS_DONE = 6;
    localparam int STS_OVF  = 5;

    // Readback select codes on ui_in[5:4]
    localparam logic [1:0] RD_RES_LO = 2'b00;
    localparam logic [1:0] RD_RES_HI = 2'b01;
    localparam logic [1:0] RD_STATUS = 2'b10;
    localparam logic [1:0] RD_GATE   = 2'b11;

    // Assemble the status byte; unused low bits read as zero
    function automatic logic [7:0] pack_status(input logic busy,
                                               input logic done,
                                               input logic ovf);
        logic [7:0] s;
        s           = 8'h00;
        s[STS_BUSY] = busy;
        s[STS_DONE] = done;
        s[STS_OVF]  = ovf;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : freq_sync_edge
// Description : Multi-flop synchronizer for an asynchronous pin followed by a
//               one-flop rising-edge detector producing a single-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the pin through the synchronizer and remember the last synced level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // High for exactly one cycle after the synced level rises
    assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/tt_um_freq_counter.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_freq_counter
// Description : Gated frequency counter. Counts rising edges of sig_in over a
//               window of G*UNIT clocks, latches a saturating result and
//               exposes result/status/G byte-wise through a registered mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_freq_counter
    import tt_freq_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 8,
    parameter int UNIT        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int                   c_TIMER_W = GATE_W + $clog2(UNIT);
    localparam logic [CNT_W-1:0]     c_CNT_MAX = '1;
    localparam logic [c_TIMER_W-1:0] c_UNIT    = c_TIMER_W'(UNIT);

    // Input field decode
    logic       w_cont;
    logic       w_load_g;
    logic [1:0] w_rd_sel;
    logic       w_unused;

    assign w_cont   = ui_in[2];
    assign w_load_g = ui_in[3];
    assign w_rd_sel = ui_in[5:4];
    assign w_unused = &{1'b0, ena, ui_in[7:6]};

    // All bidirectional pins are inputs
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    // Synchronized single-cycle pulses
    logic w_sig_pulse;
    logic w_start_pulse;

    freq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sig_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (ui_in[0]),
        .o_pulse (w_sig_pulse)
    );

    freq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (ui_in[1]),
        .o_pulse (w_start_pulse)
    );

    // Registered state
    state_t                 r_state;
    logic [GATE_W-1:0]      r_g;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       r_result;
    logic                   r_win_ovf;
    logic                   r_ovf;
    logic                   r_done;
    logic [7:0]             r_uo_out;

    // FSM decode outputs
    state_t                 w_state_next;
    logic                   w_start_ok;
    logic                   w_load_ok;
    logic                   w_arm;
    logic                   w_latch;
    logic                   w_zero_result;
    logic                   w_clear_done;

    // Datapath helpers
    logic                   w_at_max;
    logic                   w_hit_ovf;
    logic [CNT_W-1:0]       w_count_next;
    logic [c_TIMER_W-1:0]   w_reload;

    // A simultaneous load_g wins over start, so start only counts alone
    assign w_start_ok = w_start_pulse & ~w_load_g;
    assign w_load_ok  = w_load_g & (r_state != ST_GATE);

    // Saturating edge count; the final-cycle pulse is folded in the same way
    assign w_at_max     = (r_count == c_CNT_MAX);
    assign w_hit_ovf    = w_sig_pulse & w_at_max;
    assign w_count_next = (w_sig_pulse && !w_at_max) ? r_count + 1'b1 : r_count;

    // Timer runs from G*UNIT-1 down to 0, giving exactly G*UNIT counted cycles
    assign w_reload = c_TIMER_W'(r_g) * c_UNIT - c_TIMER_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_state_next  = r_state;
        w_arm         = 1'b0;
        w_latch       = 1'b0;
        w_zero_result = 1'b0;
        w_clear_done  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    w_clear_done = 1'b1;
                    if (r_g == '0) begin
                        // Empty window: finish at once with a zero result
                        w_state_next  = ST_DONE;
                        w_zero_result = 1'b1;
                    end else begin
                        w_state_next = ST_GATE;
                        w_arm        = 1'b1;
                    end
                end
            end
            ST_GATE: begin
                if (r_timer == '0) begin
                    w_latch = 1'b1;
                    if (w_cont) begin
                        // Back-to-back window: re-arm in the same cycle
                        w_arm = 1'b1;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Gate length, timer, counter, result and flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_g       <= '0;
            r_timer   <= '0;
            r_count   <= '0;
            r_result  <= '0;
            r_win_ovf <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_load_ok) begin
                r_g <= GATE_W'(uio_in);
            end

            if (w_arm) begin
                r_count   <= '0;
                r_timer   <= w_reload;
                r_win_ovf <= 1'b0;
            end else if (r_state == ST_GATE) begin
                r_count <= w_count_next;
                r_timer <= (r_timer == '0) ? '0 : r_timer - 1'b1;
                if (w_hit_ovf) begin
                    r_win_ovf <= 1'b1;
                end
            end

            if (w_latch) begin
                r_result <= w_count_next;
                r_ovf    <= r_win_ovf | w_hit_ovf;
            end else if (w_zero_result) begin
                r_result <= '0;
                r_ovf    <= 1'b0;
            end

            if (w_latch || w_zero_result) begin
                r_done <= 1'b1;
            end else if (w_clear_done) begin
                r_done <= 1'b0;
            end
        end
    end

    // Readback mux, registered for a one-cycle read latency
    logic [15:0] w_result16;
    assign w_result16 = 16'(r_result);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_uo_out <= 8'h00;
        end else begin
            case (w_rd_sel)
                RD_RES_LO: r_uo_out <= w_result16[7:0];
                RD_RES_HI: r_uo_out <= w_result16[15:8];
                RD_STATUS: r_uo_out <= pack_status(r_state == ST_GATE, r_done, r_ovf);
                RD_GATE:   r_uo_out <= 8'(r_g);
                default:   r_uo_out <= 8'h00;
            endcase
        end
    end

    assign uo_out = r_uo_out;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_freq_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_freq_counter
// Description : Scoreboard bench for the gated frequency counter. Runs a
//               16-bit and a 4-bit counter build side by side on shared pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_freq_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n  = 1'b0;
    logic       sig    = 1'b0;
    logic       start  = 1'b0;
    logic       cont   = 1'b0;
    logic       load_g = 1'b0;
    logic [1:0] rd_sel = 2'b00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] ui_in;
    logic       ena    = 1'b1;

    assign ui_in = {2'b00, rd_sel, load_g, cont, start, sig};

    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uo_out4, uio_out4, uio_oe4;

    tt_um_freq_counter #(.CNT_W(16), .GATE_W(8), .UNIT(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    tt_um_freq_counter #(.CNT_W(4), .GATE_W(8), .UNIT(16), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out4), .uio_out(uio_out4), .uio_oe(uio_oe4)
    );

    // Periodic sig_in generator: rising edge every sig_period cycles (0 = off)
    int sig_period = 0;
    int phase      = 0;
    always @(negedge clk) begin
        if (sig_period == 0) begin
            phase = 0;
            sig   = 1'b0;
        end else begin
            phase = (phase + 1 >= sig_period) ? 0 : phase + 1;
            sig   = (phase < sig_period / 2);
        end
    end

    // Scoreboard
    bit         q_which[$];
    logic [7:0] q_exp[$];
    string      q_name[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic       rd_req   = 1'b0;
    logic       req_d    = 1'b0;
    logic       final_req  = 1'b0;
    logic       final_done = 1'b0;

    always @(posedge clk) req_d <= rd_req;

    // Monitor: a read issued one cycle earlier is now visible on uo_out
    always @(negedge clk) begin
        if (req_d) begin
            n_checks++;
            if (q_exp.size() == 0) begin
                $display("FAIL sb_underflow: got read with no expected value, required queued entry");
            end else begin
                bit         w;
                logic [7:0] e;
                logic [7:0] a;
                string      nm;
                w  = q_which.pop_front();
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                a  = w ? uo_out4 : uo_out;
                if (a === e) n_pass++;
                else $display("FAIL %s: got %02h required %02h", nm, a, e);
            end
        end
        if (final_req && !final_done) begin
            final_done = 1'b1;
            n_checks++;
            if (q_exp.size() == 0) n_pass++;
            else $display("FAIL sb_drain: got %0d pending required 0", q_exp.size());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input bit which, input logic [1:0] sel, input logic [7:0] exp, input string name);
        @(negedge clk);
        rd_sel = sel;
        q_which.push_back(which);
        q_exp.push_back(exp);
        q_name.push_back(name);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic load(input logic [7:0] g);
        @(negedge clk);
        uio_in = g;
        load_g = 1'b1;
        @(negedge clk);
        load_g = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        cyc(4);
        start = 1'b0;
    endtask

    initial begin
        // 1: reset
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        rd(0, 2'b00, 8'h00, "rst_lo");
        rd(0, 2'b01, 8'h00, "rst_hi");
        rd(0, 2'b10, 8'h00, "rst_status");
        rd(0, 2'b11, 8'h00, "rst_g");
        rd(1, 2'b10, 8'h00, "rst_status4");

        // 2: basic window, G=4, edge every 8 clk
        sig_period = 8;
        load(8'd4);
        rd(0, 2'b11, 8'h04, "g_load");
        pulse_start();
        cyc(90);
        rd(0, 2'b00, 8'h08, "basic_lo");
        rd(0, 2'b01, 8'h00, "basic_hi");
        rd(0, 2'b10, 8'h40, "basic_status");
        rd(1, 2'b00, 8'h08, "basic_lo4");
        rd(1, 2'b10, 8'h40, "basic_status4");

        // 3: G=0 finishes immediately, never busy
        load(8'd0);
        rd(0, 2'b11, 8'h00, "g_zero");
        pulse_start();
        for (int i = 0; i < 8; i++) rd(0, 2'b10, 8'h40, "g0_status");
        rd(0, 2'b00, 8'h00, "g0_lo");
        rd(1, 2'b00, 8'h00, "g0_lo4");

        // 4: saturation in the 4-bit build, 32 edges in the window
        sig_period = 2;
        load(8'd4);
        pulse_start();
        cyc(90);
        rd(1, 2'b00, 8'h0F, "sat_lo4");
        rd(1, 2'b01, 8'h00, "sat_hi4");
        rd(1, 2'b10, 8'h60, "sat_status4");
        rd(0, 2'b00, 8'h20, "wide_lo");
        rd(0, 2'b10, 8'h40, "wide_status");

        // 5: continuous mode, G=2, edge every 4 clk
        sig_period = 4;
        cont = 1'b1;
        load(8'd2);
        pulse_start();
        cyc(40);
        rd(0, 2'b10, 8'hC0, "cont_status");
        rd(0, 2'b00, 8'h08, "cont_lo_w1");
        cyc(32);
        rd(0, 2'b00, 8'h08, "cont_lo_w2");
        rd(1, 2'b00, 8'h08, "cont_lo4");
        rd(1, 2'b10, 8'hC0, "cont_status4");
        cont = 1'b0;
        cyc(40);
        rd(0, 2'b10, 8'h40, "cont_stop_status");
        rd(0, 2'b00, 8'h08, "cont_stop_lo");
        rd(1, 2'b10, 8'h40, "cont_stop_status4");

        // 6a: reset mid-window aborts with no latch
        load(8'd4);
        pulse_start();
        cyc(20);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(80);
        rd(0, 2'b00, 8'h00, "abort_lo");
        rd(0, 2'b01, 8'h00, "abort_hi");
        rd(0, 2'b10, 8'h00, "abort_status");
        rd(0, 2'b11, 8'h00, "abort_g");
        rd(1, 2'b10, 8'h00, "abort_status4");

        // 6b: load_g coinciding with the start pulse wins
        start = 1'b1;
        cyc(2);
        uio_in = 8'd3;
        load_g = 1'b1;
        cyc(1);
        load_g = 1'b0;
        cyc(3);
        start = 1'b0;
        cyc(5);
        rd(0, 2'b10, 8'h00, "ldstart_status");
        rd(0, 2'b11, 8'h03, "ldstart_g");

        // 6c: load_g ignored while busy
        pulse_start();
        cyc(5);
        rd(0, 2'b10, 8'h80, "busy_status");
        load(8'd9);
        rd(0, 2'b11, 8'h03, "busy_g");
        rd(1, 2'b10, 8'h80, "busy_status4");

        cyc(3);
        final_req = 1'b1;
        cyc(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
